// File: rtl/keypad_scan_4x4.sv
// 4x4 active-low matrix keypad scanner with frame-based debounce and one-hot key output.
// Latency: code appears one cycle after the DEBOUNCE_FRAMES-th identical frame ends.
// Backpressure: none; outputs are level/strobe registers sampled by the downstream decoder.
module keypad_scan_4x4 #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 20
) (
  input  logic        clk,
  input  logic        RSTn,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic [15:0] onehot,
  output logic        key_valid,
  output logic        key_pulse
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

  typedef enum logic [1:0] {COL0, COL1, COL2, COL3} state_t;

  logic [3:0]    r_sync1;
  logic [3:0]    r_row_s;
  state_t        r_state;
  logic [DW-1:0] r_dwell;
  logic [3:0]    r_col_out;
  logic [11:0]   r_frame_lo;
  logic [15:0]   r_last_frame;
  logic [CW-1:0] r_stab_cnt;
  logic [15:0]   r_stable;
  logic [15:0]   r_onehot;
  logic          r_key_valid;
  logic          r_key_pulse;

  logic          w_last;
  logic [3:0]    w_row_hit;
  logic [15:0]   w_frame;
  logic          w_frame_end;
  logic [CW-1:0] w_stab_next;
  logic          w_single;
  logic [15:0]   w_qual;

  assign w_last      = (r_dwell == DW'(SCAN_DIV - 1));
  assign w_row_hit   = ~r_row_s;
  // COL3 bits come straight from the synchroniser so the evaluated frame is complete.
  assign w_frame     = {w_row_hit, r_frame_lo};
  assign w_frame_end = w_last && (r_state == COL3);
  assign w_single    = (r_stable != 16'h0000) && ((r_stable & (r_stable - 16'h0001)) == 16'h0000);
  assign w_qual      = w_single ? r_stable : 16'h0000;

  // Two-flop synchroniser; idle rows read as released.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_sync1 <= 4'b1111;
      r_row_s <= 4'b1111;
    end else begin
      r_sync1 <= row_in;
      r_row_s <= r_sync1;
    end
  end

  // Column scan FSM with dwell counter and registered column drive.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_state   <= COL0;
      r_dwell   <= '0;
      r_col_out <= 4'b1110;
    end else if (w_last) begin
      r_dwell <= '0;
      case (r_state)
        COL0:    begin r_state <= COL1; r_col_out <= 4'b1101; end
        COL1:    begin r_state <= COL2; r_col_out <= 4'b1011; end
        COL2:    begin r_state <= COL3; r_col_out <= 4'b0111; end
        default: begin r_state <= COL0; r_col_out <= 4'b1110; end
      endcase
    end else begin
      r_dwell <= r_dwell + DW'(1);
    end
  end

  // Capture the row hits of columns 0..2 on their last dwell cycle.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_frame_lo <= '0;
    end else if (w_last) begin
      case (r_state)
        COL0:    r_frame_lo[3:0]  <= w_row_hit;
        COL1:    r_frame_lo[7:4]  <= w_row_hit;
        COL2:    r_frame_lo[11:8] <= w_row_hit;
        default: r_frame_lo       <= r_frame_lo;
      endcase
    end
  end

  // Stability count the frame-end evaluation will produce.
  always_comb begin
    w_stab_next = CW'(1);
    if (w_frame == r_last_frame) begin
      w_stab_next = (r_stab_cnt == CW'(DEBOUNCE_FRAMES)) ? r_stab_cnt : r_stab_cnt + CW'(1);
    end
  end

  // Frame-end debounce: publish a frame once it has repeated DEBOUNCE_FRAMES times.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_last_frame <= '0;
      r_stab_cnt   <= '0;
      r_stable     <= '0;
    end else if (w_frame_end) begin
      r_last_frame <= w_frame;
      r_stab_cnt   <= w_stab_next;
      if (w_stab_next == CW'(DEBOUNCE_FRAMES)) begin
        r_stable <= w_frame;
      end
    end
  end

  // Output stage: only single-key frames pass; strobe on each new nonzero code.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_onehot    <= '0;
      r_key_valid <= 1'b0;
      r_key_pulse <= 1'b0;
    end else begin
      r_onehot    <= w_qual;
      r_key_valid <= |w_qual;
      r_key_pulse <= (w_qual != 16'h0000) && (w_qual != r_onehot);
    end
  end

  assign col_out   = r_col_out;
  assign onehot    = r_onehot;
  assign key_valid = r_key_valid;
  assign key_pulse = r_key_pulse;

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Bench for keypad_scan_4x4: a keypad model drives the rows from the pressed-key set and col_out,
// and a frame-level debounce model predicts onehot/key_valid/key_pulse at every frame boundary.
// All key changes land just after the onehot update edge so each frame sees one key set.
module tb_keypad_scan_4x4;

  localparam int SD = 4;
  localparam int DF = 3;
  localparam int FR = 4 * SD;

  logic        clk = 1'b0;
  logic        RSTn = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] onehot;
  logic        key_valid;
  logic        key_pulse;

  logic [15:0] keys = 16'h0000;
  int total = 0;
  int bad = 0;
  int pulse_seen = 0;
  int m_pulses = 0;

  logic [16:0] m_hist[$];
  logic [15:0] m_stable = 16'h0000;
  logic [15:0] m_prev = 16'h0000;
  logic [15:0] exp_onehot = 16'h0000;
  logic        exp_pulse = 1'b0;

  keypad_scan_4x4 #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
    .clk       (clk),
    .RSTn      (RSTn),
    .row_in    (row_in),
    .col_out   (col_out),
    .onehot    (onehot),
    .key_valid (key_valid),
    .key_pulse (key_pulse)
  );

  always #5 clk = ~clk;

  // Physical keypad: a row is pulled low by any pressed key whose column is driven low.
  always_comb begin
    row_in = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[4*c + r] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (RSTn && key_pulse === 1'b1) pulse_seen++;
  end

  task automatic model_reset();
    m_hist.delete();
    m_stable   = 16'h0000;
    m_prev     = 16'h0000;
    exp_onehot = 16'h0000;
    exp_pulse  = 1'b0;
  endtask

  // One observed frame; bit 16 marks a frame whose content is indeterminate.
  task automatic model_push(input logic [16:0] v);
    int run;
    m_hist.push_back(v);
    if (m_hist.size() > 8) void'(m_hist.pop_front());
    run = 0;
    for (int i = m_hist.size() - 1; i >= 0; i--) begin
      if (m_hist[i] == v) run++;
      else break;
    end
    if (run >= DF && !v[16]) m_stable = v[15:0];
    exp_onehot = ($countones(m_stable) == 1) ? m_stable : 16'h0000;
    exp_pulse  = (exp_onehot != 16'h0000) && (exp_onehot != m_prev);
    if (exp_pulse) m_pulses++;
    m_prev = exp_onehot;
  endtask

  // Hold a key set for one whole frame, ending just after the next output update.
  task automatic step_frame(input logic [15:0] mask);
    keys = mask;
    repeat (FR) @(posedge clk);
    #1;
    model_push({1'b0, mask});
  endtask

  task automatic test_reset();
    logic [3:0] want;
    keys = 16'h0000;
    #2 RSTn = 1'b0;
    #5;
    total++; if (col_out !== 4'b1110) begin bad++; $display("FAIL reset col_out: got %b want 1110", col_out); end
    total++; if (onehot !== 16'h0000) begin bad++; $display("FAIL reset onehot: got %h want 0000", onehot); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset key_valid: got %b want 0", key_valid); end
    total++; if (key_pulse !== 1'b0) begin bad++; $display("FAIL reset key_pulse: got %b want 0", key_pulse); end
    @(negedge clk) RSTn = 1'b1;
    model_reset();
    for (int n = 1; n <= FR + 1; n++) begin
      @(posedge clk);
      #1;
      want = ~(4'b0001 << ((n / SD) % 4));
      total++; if (col_out !== want) begin bad++; $display("FAIL scan col_out edge %0d: got %b want %b", n, col_out, want); end
    end
    model_push(17'h0);
    total++; if (onehot !== exp_onehot) begin bad++; $display("FAIL reset idle onehot: got %h want %h", onehot, exp_onehot); end
  endtask

  task automatic test_single_key();
    for (int f = 0; f < 8; f++) begin
      step_frame(f < 4 ? 16'h0200 : 16'h0000);
      total++; if (onehot !== exp_onehot) begin bad++; $display("FAIL single onehot f%0d: got %h want %h", f, onehot, exp_onehot); end
      total++; if (key_valid !== (exp_onehot != 16'h0)) begin bad++; $display("FAIL single key_valid f%0d: got %b want %b", f, key_valid, exp_onehot != 16'h0); end
      total++; if (key_pulse !== exp_pulse) begin bad++; $display("FAIL single key_pulse f%0d: got %b want %b", f, key_pulse, exp_pulse); end
      if (f == 3) begin
        total++; if (onehot !== 16'h0200) begin bad++; $display("FAIL single pressed code: got %h want 0200", onehot); end
      end
    end
    total++; if (onehot !== 16'h0000) begin bad++; $display("FAIL single released code: got %h want 0000", onehot); end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 20; i++) begin
      keys = (i % 2 == 0) ? 16'h0200 : 16'h0000;
      repeat (6) @(posedge clk);
      #1;
      total++; if (onehot !== 16'h0000) begin bad++; $display("FAIL bounce onehot step %0d: got %h want 0000", i, onehot); end
      total++; if (key_pulse !== 1'b0) begin bad++; $display("FAIL bounce key_pulse step %0d: got %b want 0", i, key_pulse); end
    end
    keys = 16'h0000;
    repeat (8) @(posedge clk);
    #1;
    for (int f = 0; f < 7; f++) model_push(17'h10000);
    model_push(17'h0);
    for (int f = 0; f < 4; f++) begin
      step_frame(16'h0200);
      total++; if (onehot !== exp_onehot) begin bad++; $display("FAIL bounce hold onehot f%0d: got %h want %h", f, onehot, exp_onehot); end
      total++; if (key_pulse !== exp_pulse) begin bad++; $display("FAIL bounce hold key_pulse f%0d: got %b want %b", f, key_pulse, exp_pulse); end
    end
    total++; if (onehot !== 16'h0200) begin bad++; $display("FAIL bounce settled code: got %h want 0200", onehot); end
    for (int f = 0; f < 3; f++) step_frame(16'h0000);
  endtask

  task automatic test_two_keys();
    for (int f = 0; f < 10; f++) begin
      step_frame(f < 6 ? 16'h8008 : 16'h0008);
      total++; if (onehot !== exp_onehot) begin bad++; $display("FAIL twokey onehot f%0d: got %h want %h", f, onehot, exp_onehot); end
      total++; if (key_valid !== (exp_onehot != 16'h0)) begin bad++; $display("FAIL twokey key_valid f%0d: got %b want %b", f, key_valid, exp_onehot != 16'h0); end
      total++; if (key_pulse !== exp_pulse) begin bad++; $display("FAIL twokey key_pulse f%0d: got %b want %b", f, key_pulse, exp_pulse); end
      if (f == 5) begin
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL twokey held valid: got %b want 0", key_valid); end
      end
    end
    total++; if (onehot !== 16'h0008) begin bad++; $display("FAIL twokey remaining code: got %h want 0008", onehot); end
  endtask

  task automatic test_roll();
    for (int f = 0; f < 8; f++) begin
      step_frame(f < 4 ? 16'h0080 : 16'h8000);
      total++; if (onehot !== exp_onehot) begin bad++; $display("FAIL roll onehot f%0d: got %h want %h", f, onehot, exp_onehot); end
      total++; if (key_pulse !== exp_pulse) begin bad++; $display("FAIL roll key_pulse f%0d: got %b want %b", f, key_pulse, exp_pulse); end
      if (f == 3) begin
        total++; if (onehot !== 16'h0080) begin bad++; $display("FAIL roll first code: got %h want 0080", onehot); end
      end
    end
    total++; if (onehot !== 16'h8000) begin bad++; $display("FAIL roll second code: got %h want 8000", onehot); end
  endtask

  task automatic test_reset_mid_press();
    for (int f = 0; f < 4; f++) step_frame(16'h0200);
    total++; if (onehot !== 16'h0200) begin bad++; $display("FAIL midreset pre code: got %h want 0200", onehot); end
    #2 RSTn = 1'b0;
    #1;
    total++; if (onehot !== 16'h0000) begin bad++; $display("FAIL midreset onehot: got %h want 0000", onehot); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL midreset key_valid: got %b want 0", key_valid); end
    total++; if (col_out !== 4'b1110) begin bad++; $display("FAIL midreset col_out: got %b want 1110", col_out); end
    model_reset();
    @(negedge clk) RSTn = 1'b1;
    @(posedge clk);
    #1;
    for (int f = 0; f < 4; f++) begin
      step_frame(16'h0200);
      total++; if (onehot !== exp_onehot) begin bad++; $display("FAIL midreset requal onehot f%0d: got %h want %h", f, onehot, exp_onehot); end
      total++; if (key_pulse !== exp_pulse) begin bad++; $display("FAIL midreset requal key_pulse f%0d: got %b want %b", f, key_pulse, exp_pulse); end
    end
  endtask

  task automatic test_random();
    logic [15:0] mask;
    int hold;
    mask = 16'h0000;
    hold = 0;
    for (int f = 0; f < 60; f++) begin
      if (hold == 0) begin
        case ($urandom_range(0, 3))
          0:       mask = 16'h0000;
          3:       mask = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
          default: mask = 16'h0001 << $urandom_range(0, 15);
        endcase
        hold = $urandom_range(1, 5);
      end
      hold--;
      step_frame(mask);
      total++; if (onehot !== exp_onehot) begin bad++; $display("FAIL random onehot f%0d: got %h want %h", f, onehot, exp_onehot); end
      total++; if (key_valid !== (exp_onehot != 16'h0)) begin bad++; $display("FAIL random key_valid f%0d: got %b want %b", f, key_valid, exp_onehot != 16'h0); end
      total++; if (key_pulse !== exp_pulse) begin bad++; $display("FAIL random key_pulse f%0d: got %b want %b", f, key_pulse, exp_pulse); end
    end
  endtask

  task automatic test_pulse_width();
    @(negedge clk);
    total++; if (pulse_seen !== m_pulses) begin bad++; $display("FAIL pulse cycles: got %0d want %0d", pulse_seen, m_pulses); end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_bounce();
    test_two_keys();
    test_roll();
    test_reset_mid_press();
    test_random();
    test_pulse_width();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
